// File: rtl/spi_reg_bridge_if.sv
// Bus bundle between the SPI slave driver / register file and spi_reg_bridge.
// The bridge uses the slave modport; the driving environment uses master.
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int XCNT_W = 8
);
  // Handshake: rec_ready, send_ready, done, reg_wr and reg_rd are single-cycle
  // strobes with no back-pressure. rec_data qualifies rec_ready, send_data is
  // sampled by the slave on send_ready, and reg_rdata is valid exactly one
  // cycle after reg_rd.
  logic [7:0]        rec_data;
  logic              rec_ready;
  logic              send_ready;
  logic              done;
  logic [7:0]        send_data;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [7:0]        reg_rdata;
  logic [XCNT_W-1:0] frame_bytes;
  logic              busy;

  modport slave (
    input  rec_data, rec_ready, send_ready, done, reg_rdata,
    output send_data, reg_addr, reg_wdata, reg_wr, reg_rd, frame_bytes, busy
  );

  modport master (
    output rec_data, rec_ready, send_ready, done, reg_rdata,
    input  send_data, reg_addr, reg_wdata, reg_wr, reg_rd, frame_bytes, busy
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI command decoder: turns byte frames into single-cycle register accesses.
// Define SPI_REG_BRIDGE_BURST_EN for auto-incrementing addresses; default is fixed-address (FIFO-style).
module spi_reg_bridge #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter int         XCNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_reg_bridge_if.slave        bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DATA  = 2'd1,
    RD_FETCH = 2'd2,
    RD_DATA  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        send_data_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [7:0]        reg_wdata_q;
  logic              reg_wr_q;
  logic              reg_rd_q;
  logic              cap_q;
  logic              first_q;
  logic [XCNT_W-1:0] frame_q;
  logic [XCNT_W-1:0] frame_d;
  logic              busy_q;
  logic              wait_q;
  logic              busy_shadow_q;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_accept;

`ifdef SPI_REG_BRIDGE_BURST_EN
  assign addr_d = addr_q + ADDR_W'(1);
`else
  assign addr_d = addr_q;
`endif

  assign frame_d    = (frame_q == {XCNT_W{1'b1}}) ? frame_q : frame_q + XCNT_W'(1);
  assign cmd_addr   = bus.rec_data[ADDR_W-1:0];
  assign cmd_accept = bus.rec_ready & ~wait_q & ~bus.done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      send_data_q <= STATUS_BYTE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      cap_q       <= 1'b0;
      first_q     <= 1'b0;
      frame_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      cap_q    <= reg_rd_q;
      unique case (state_q)
        IDLE: begin
          send_data_q <= STATUS_BYTE;
          if (cmd_accept) begin
            addr_q  <= cmd_addr;
            frame_q <= '0;
            busy_q  <= 1'b1;
            if (bus.rec_data[7]) begin
              state_q    <= RD_FETCH;
              reg_rd_q   <= 1'b1;
              reg_addr_q <= cmd_addr;
            end else begin
              state_q <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (bus.rec_ready) begin
            reg_wr_q    <= 1'b1;
            reg_addr_q  <= addr_q;
            reg_wdata_q <= bus.rec_data;
            addr_q      <= addr_d;
            frame_q     <= frame_d;
          end
        end
        RD_FETCH: begin
          if (cap_q) begin
            send_data_q <= bus.reg_rdata;
            first_q     <= 1'b1;
            state_q     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (cap_q) send_data_q <= bus.reg_rdata;
          // The first send_ready is the slave reloading the turnaround byte.
          if (bus.send_ready) begin
            if (first_q) begin
              first_q <= 1'b0;
            end else if (!bus.done) begin
              addr_q     <= addr_d;
              reg_addr_q <= addr_d;
              reg_rd_q   <= 1'b1;
              frame_q    <= frame_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (bus.done) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        send_data_q <= STATUS_BYTE;
        reg_rd_q    <= 1'b0;
        cap_q       <= 1'b0;
        first_q     <= 1'b0;
      end
    end
  end

  // Survives rst so a frame cut by reset is skipped until its chip select ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (busy_shadow_q) wait_q <= 1'b1;
    end else begin
      busy_shadow_q <= busy_q;
      if (bus.done) wait_q <= 1'b0;
    end
  end

  assign bus.send_data   = send_data_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wdata   = reg_wdata_q;
  assign bus.reg_wr      = reg_wr_q;
  assign bus.reg_rd      = reg_rd_q;
  assign bus.frame_bytes = frame_q;
  assign bus.busy        = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: stimulus pushes expected register-bus
// accesses into queues, negedge monitors pop and compare them.
module tb_spi_reg_bridge;
  localparam int ADDR_W = 7;
  localparam int XCNT_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic [ADDR_W+7:0] exp_wr_q[$];
  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [7:0]        regs [0:127];

  spi_reg_bridge_if #(.ADDR_W(ADDR_W), .XCNT_W(XCNT_W)) bus ();

  spi_reg_bridge #(.ADDR_W(ADDR_W), .STATUS_BYTE(8'hA5), .XCNT_W(XCNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Register file read port: data one cycle after reg_rd.
  always @(posedge clk) begin
    if (bus.reg_rd) bus.reg_rdata <= regs[bus.reg_addr];
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [ADDR_W+7:0] ew;
    logic [ADDR_W-1:0] er;
    if (bus.reg_wr || bus.reg_rd)
      check("wr_rd_exclusive", 32'(bus.reg_wr & bus.reg_rd), 32'd0);
    if (bus.reg_wr) begin
      if (exp_wr_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 bus.reg_addr, bus.reg_wdata);
      end else begin
        ew = exp_wr_q.pop_front();
        check("reg_wr", 32'({bus.reg_addr, bus.reg_wdata}), 32'(ew));
      end
    end
    if (bus.reg_rd) begin
      if (exp_rd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_unexpected: got addr 0x%0h, expected no read", bus.reg_addr);
      end else begin
        er = exp_rd_q.pop_front();
        check("reg_rd_addr", 32'(bus.reg_addr), 32'(er));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one cycle of strobes.
  task automatic pulse(input logic rr, input logic sr, input logic dn, input logic [7:0] d);
    bus.rec_data   = d;
    bus.rec_ready  = rr;
    bus.send_ready = sr;
    bus.done       = dn;
    @(posedge clk); #1;
    bus.rec_ready  = 1'b0;
    bus.send_ready = 1'b0;
    bus.done       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  logic burst;
  logic [7:0] exp_sd [0:2];

  initial begin
`ifdef SPI_REG_BRIDGE_BURST_EN
    burst = 1'b1;
`else
    burst = 1'b0;
`endif
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[1] = 8'h77; regs[2] = 8'h10; regs[3] = 8'h20; regs[4] = 8'h30; regs[5] = 8'h55;
    exp_sd[0] = burst ? 8'h20 : 8'h10;
    exp_sd[1] = burst ? 8'h30 : 8'h10;
    exp_sd[2] = burst ? 8'h55 : 8'h10;

    rst = 1'b1;
    bus.rec_data = 8'h00; bus.rec_ready = 1'b0; bus.send_ready = 1'b0; bus.done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_send_data", 32'(bus.send_data), 32'hA5);
    check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
    check("rst_strobes", 32'({bus.reg_wr, bus.reg_rd}), 32'd0);
    check("rst_frame", 32'(bus.frame_bytes), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    pulse(1'b0, 1'b0, 1'b1, 8'h00);

    // Write burst 0x05: 11,22,33
    push_wr(7'h05, 8'h11);
    push_wr(burst ? 7'h06 : 7'h05, 8'h22);
    push_wr(burst ? 7'h07 : 7'h05, 8'h33);
    pulse(1'b1, 1'b0, 1'b0, 8'h05);
    check("wr_busy_set", 32'(bus.busy), 32'd1);
    check("wr_state", 32'(dbg_state), 32'(S_WR));
    pulse(1'b1, 1'b0, 1'b0, 8'h11);
    pulse(1'b1, 1'b0, 1'b0, 8'h22);
    pulse(1'b1, 1'b0, 1'b0, 8'h33);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    check("wr_frame_bytes", 32'(bus.frame_bytes), 32'd3);
    check("wr_busy_clear", 32'(bus.busy), 32'd0);

    // Read burst 0x82
    exp_rd_q.push_back(7'h02);
    pulse(1'b1, 1'b0, 1'b0, 8'h82);
    idle(2);
    check("rd_first_data", 32'(bus.send_data), 32'h10);
    check("rd_state", 32'(dbg_state), 32'(S_RD));
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);
    check("rd_turnaround_hold", 32'(bus.send_data), 32'h10);
    for (int k = 0; k < 3; k++) begin
      exp_rd_q.push_back(burst ? 7'(3 + k) : 7'h02);
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      idle(2);
      check("rd_next_data", 32'(bus.send_data), 32'(exp_sd[k]));
    end
    check("rd_frame_bytes", 32'(bus.frame_bytes), 32'd3);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    check("rd_done_status", 32'(bus.send_data), 32'hA5);
    check("rd_done_busy", 32'(bus.busy), 32'd0);

    // Address wrap 0x7F
    push_wr(7'h7F, 8'hAA);
    push_wr(burst ? 7'h00 : 7'h7F, 8'hBB);
    pulse(1'b1, 1'b0, 1'b0, 8'h7F);
    pulse(1'b1, 1'b0, 1'b0, 8'hAA);
    pulse(1'b1, 1'b0, 1'b0, 8'hBB);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    check("wrap_frame_bytes", 32'(bus.frame_bytes), 32'd2);

    // Early done with second send_ready
    exp_rd_q.push_back(7'h01);
    pulse(1'b1, 1'b0, 1'b0, 8'h81);
    idle(2);
    check("early_first_data", 32'(bus.send_data), 32'h77);
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    pulse(1'b0, 1'b1, 1'b1, 8'h00);
    check("early_status", 32'(bus.send_data), 32'hA5);
    check("early_state", 32'(dbg_state), 32'(S_IDLE));
    check("early_busy", 32'(bus.busy), 32'd0);
    idle(3);

    // Reset in the middle of a write frame
    push_wr(7'h03, 8'h11);
    pulse(1'b1, 1'b0, 1'b0, 8'h03);
    pulse(1'b1, 1'b0, 1'b0, 8'h11);
    idle(1);
    rst = 1'b1;
    #2;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    check("midrst_reg_addr", 32'(bus.reg_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 8'h44);
    idle(2);
    check("midrst_ignored_state", 32'(dbg_state), 32'(S_IDLE));
    check("midrst_ignored_busy", 32'(bus.busy), 32'd0);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    push_wr(7'h03, 8'h55);
    pulse(1'b1, 1'b0, 1'b0, 8'h03);
    pulse(1'b1, 1'b0, 1'b0, 8'h55);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    idle(1);

    // rec_ready together with done: write completes, command in IDLE is dropped
    push_wr(7'h10, 8'h66);
    pulse(1'b1, 1'b0, 1'b0, 8'h10);
    pulse(1'b1, 1'b0, 1'b1, 8'h66);
    check("wrdone_state", 32'(dbg_state), 32'(S_IDLE));
    check("wrdone_frame", 32'(bus.frame_bytes), 32'd1);
    pulse(1'b1, 1'b0, 1'b1, 8'h20);
    idle(2);
    check("idledone_state", 32'(dbg_state), 32'(S_IDLE));
    check("idledone_busy", 32'(bus.busy), 32'd0);
    check("idledone_frame_hold", 32'(bus.frame_bytes), 32'd1);

    // Repeated access to one address unless bursting
    push_wr(7'h04, 8'h01);
    push_wr(burst ? 7'h05 : 7'h04, 8'h02);
    pulse(1'b1, 1'b0, 1'b0, 8'h04);
    pulse(1'b1, 1'b0, 1'b0, 8'h01);
    pulse(1'b1, 1'b0, 1'b0, 8'h02);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    check("fifo_frame_bytes", 32'(bus.frame_bytes), 32'd2);

    idle(4);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of the full-duplex SPI slave driver. Consumes its received bytes and ready strobes, and supplies the next response byte back to it.
- Decodes a simple command protocol from the LS2K host into single-cycle register-bus accesses: configuration, status and vibration sample registers.
- The first byte of each chip-select frame is a command. Following bytes are write data, or dummy bytes clocked out as read data.

Parameters:
- ADDR_W, 7, register address width (1..7); address taken from cmd[ADDR_W-1:0]
- STATUS_BYTE, 8'hA5, value presented on send_data while idle/awaiting command
- XCNT_W, 8, width of frame byte counter (saturating)

Ports:
- clk  in  1  system clock (same clock as SPI slave driver)
- rst  in  1  asynchronous, active-high reset
- rec_data  in  8  byte received from SPI slave driver
- rec_ready  in  1  1-cycle pulse: rec_data valid
- send_ready  in  1  1-cycle pulse: slave has loaded send_data into its shift buffer
- done  in  1  1-cycle pulse: chip select released, frame ended
- send_data  out  8  next response byte to SPI slave driver
- reg_addr  out  ADDR_W  register bus address
- reg_wdata  out  8  register write data
- reg_wr  out  1  1-cycle write strobe
- reg_rd  out  1  1-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_rd
- frame_bytes  out  XCNT_W  data bytes transferred in last/current frame, saturating
- busy  out  1  high from command byte accepted until done

Behaviour:
- Reset values: send_data=STATUS_BYTE, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, frame_bytes=0, busy=0, state=IDLE.
- Command byte format:
  - bit7=1 means read, bit7=0 means write.
  - bits[ADDR_W-1:0] are the start address.
  - bits[6:ADDR_W] are ignored.
- State IDLE:
  - send_data held at STATUS_BYTE.
  - On rec_ready: latch address, clear frame_bytes, busy<=1.
  - bit7=0 goes to WR_DATA.
  - bit7=1 goes to RD_FETCH and issues reg_rd with reg_addr=addr on the next cycle.
- State WR_DATA:
  - Each rec_ready gives reg_wr=1 for 1 cycle, with reg_addr=addr and reg_wdata=rec_data, registered (1 cycle after rec_ready).
  - Then addr<=addr+1 and frame_bytes++.
- State RD_FETCH:
  - 1 cycle after reg_rd, capture reg_rdata into send_data.
  - Then go to RD_DATA.
  - Latency from command rec_ready to send_data valid is 3 clk.
- State RD_DATA:
  - The first send_ready after entry is ignored: it is the slave's reload for the turnaround byte.
  - Each later send_ready means the current send_data was consumed: addr<=addr+1, frame_bytes++, issue reg_rd, refresh send_data 2 cycles later.
  - rec_ready is ignored (master bytes are don't-care).
- Read frame layout on the host side:
  - byte0 = cmd, byte1 = turnaround (returns reg[addr]).
  - Each later byte returns the next sequential register.
- done: any state goes to IDLE next cycle.
  - busy<=0, send_data<=STATUS_BYTE, and any pending reg_rd is dropped.
  - frame_bytes holds its value until the next command.
- Address wrap: addr 2^ADDR_W-1 increments to 0.
- frame_bytes saturates at 2^XCNT_W-1.
- Simultaneous events:
  - rec_ready+done in WR_DATA: the write is performed, then IDLE.
  - send_ready+done in RD_DATA: no new reg_rd, go to IDLE.
  - rec_ready+done in IDLE: the command is discarded.
- reg_wr and reg_rd are never high in the same cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. The rest of the frame is treated as a new frame only after the next done.
  - A wait flag is set by reset while busy and cleared by done.
  - Bytes arriving while the flag is set are ignored.

Optional Feature:
- Macro: SPI_REG_BRIDGE_BURST_EN.
- Defined: address auto-increments after each write byte and after each consumed read byte, as described above.
- Undefined: address stays fixed for the whole frame, giving FIFO-style repeated access to one register.
  - Every write byte goes to the same address.
  - Every read refetches the same address.
  - frame_bytes still counts.

Test Plan:
- Write burst: rec_ready bytes 0x05,0x11,0x22,0x33 then done -> reg_wr at addr 5,6,7 with data 0x11,0x22,0x33; frame_bytes=3; busy falls after done.
- Read burst: cmd 0x82, model regs[2..4]=0x10,0x20,0x30, then four send_ready pulses -> send_data=0x10 within 3 clk of cmd; after 2nd, 3rd and 4th send_ready it becomes 0x20, 0x30, regs[5]; first send_ready causes no reg_rd.
- Wrap: write cmd 0x7F, data 0xAA,0xBB -> writes at addr 0x7F then 0x00.
- Early done: read cmd 0x81 with done on the same cycle as the 2nd send_ready -> no reg_rd issued; send_data=0xA5 next cycle; state IDLE.
- Reset mid-write: after cmd 0x03 and one data byte, pulse rst; further rec_ready 0x44 -> no reg_wr; after done, cmd 0x03/0x55 -> reg_wr addr 3 data 0x55.
- With SPI_REG_BRIDGE_BURST_EN undefined: write cmd 0x04, data 0x01,0x02 -> both writes at addr 4; frame_bytes=2.
